// File: rtl/bfloat16_divider.sv
// rtl/bfloat16_divider.sv - iterative restoring bfloat16 divider (truncating, FTZ)
// Define BF16_DIV_SPECIALS_EN to decode exp==8'hFF operands as inf/NaN at capture.
module bfloat16_divider #(
    parameter int ITER_PER_CYCLE = 1,
    parameter int BIAS           = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_next;
    logic        sign;
    logic [9:0]  exp_q;
    logic [8:0]  rem;
    logic [7:0]  sb;
    logic [6:0]  q;
    logic [2:0]  cnt;

    logic        cap_sign;
    logic        a_zero, b_zero;
    logic [7:0]  cap_sa, cap_sb;
    logic [9:0]  cap_exp_raw;
    logic        cap_lt;
    logic        cap_special;
    logic [15:0] cap_result;
    logic        cap_dz;

    logic [8:0]  rem_n;
    logic [6:0]  q_n;
    logic        last_iter;
    logic [15:0] final_result;

    assign cap_sign    = a[15] ^ b[15];
    assign a_zero      = (a[14:7] == 8'h00);
    assign b_zero      = (b[14:7] == 8'h00);
    assign cap_sa      = {1'b1, a[6:0]};
    assign cap_sb      = {1'b1, b[6:0]};
    assign cap_exp_raw = {2'b00, a[14:7]} - {2'b00, b[14:7]} + 10'(BIAS);
    assign cap_lt      = (cap_sa < cap_sb);

    always_comb begin
        cap_special = 1'b0;
        cap_result  = 16'h0000;
        cap_dz      = 1'b0;
`ifdef BF16_DIV_SPECIALS_EN
        if (((a[14:7] == 8'hFF) && (a[6:0] != 7'h0)) ||
            ((b[14:7] == 8'hFF) && (b[6:0] != 7'h0)) ||
            ((a[14:7] == 8'hFF) && (b[14:7] == 8'hFF))) begin
            cap_special = 1'b1;
            cap_result  = 16'h7FC0;
        end else if (a[14:7] == 8'hFF) begin
            cap_special = 1'b1;
            cap_result  = {cap_sign, 8'hFF, 7'h00};
        end else if (b[14:7] == 8'hFF) begin
            cap_special = 1'b1;
            cap_result  = {cap_sign, 15'h0000};
        end else
`endif
        if (a_zero && b_zero) begin
            cap_special = 1'b1;
            cap_result  = 16'h7FC0;
        end else if (a_zero) begin
            cap_special = 1'b1;
            cap_result  = {cap_sign, 15'h0000};
        end else if (b_zero) begin
            cap_special = 1'b1;
            cap_result  = {cap_sign, 8'hFF, 7'h00};
            cap_dz      = 1'b1;
        end
    end

    // The leading quotient bit is always 1, so only the low 7 bits are kept;
    // after 8 shifts q_n holds exactly the result mantissa.
    always_comb begin
        rem_n = rem;
        q_n   = q;
        for (int i = 0; i < ITER_PER_CYCLE; i++) begin
            if (rem_n >= {1'b0, sb}) begin
                q_n   = {q_n[5:0], 1'b1};
                rem_n = rem_n - {1'b0, sb};
            end else begin
                q_n   = {q_n[5:0], 1'b0};
            end
            rem_n = rem_n << 1;
        end
    end

    assign last_iter = (cnt == 3'(8 - ITER_PER_CYCLE));

    always_comb begin
        if ($signed(exp_q) <= 10'sd0) begin
            final_result = {sign, 15'h0000};
        end else if ($signed(exp_q) >= 10'sd255) begin
            final_result = {sign, 8'hFF, 7'h00};
        end else begin
            final_result = {sign, exp_q[7:0], q_n};
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = cap_special ? DONE : CALC;
            CALC:    if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign     <= 1'b0;
            exp_q    <= 10'h000;
            rem      <= 9'h000;
            sb       <= 8'h00;
            q        <= 7'h00;
            cnt      <= 3'h0;
            result   <= 16'h0000;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= cap_sign;
                        sb   <= cap_sb;
                        q    <= 7'h00;
                        cnt  <= 3'h0;
                        if (cap_special) begin
                            result   <= cap_result;
                            div_zero <= cap_dz;
                        end else begin
                            div_zero <= 1'b0;
                            rem      <= cap_lt ? {cap_sa, 1'b0} : {1'b0, cap_sa};
                            exp_q    <= cap_lt ? (cap_exp_raw - 10'd1) : cap_exp_raw;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_n;
                    q   <= q_n;
                    cnt <= cnt + 3'(ITER_PER_CYCLE);
                    if (last_iter) begin
                        result <= final_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_bfloat16_divider.sv
// tb/tb_bfloat16_divider.sv - randomized scoreboard bench for bfloat16_divider
module tb_bfloat16_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] a, b;
    logic        out_valid, out_ready;
    logic [15:0] result;
    logic        div_zero;

    logic        in_valid8, in_ready8;
    logic [15:0] a8, b8;
    logic        out_valid8, out_ready8;
    logic [15:0] result8;
    logic        div_zero8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode;
    logic rnd_bit = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

    assign out_ready  = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? rnd_bit : 1'b0;
    assign out_ready8 = 1'b1;

    bfloat16_divider #(.ITER_PER_CYCLE(1), .BIAS(127)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .div_zero(div_zero)
    );

    bfloat16_divider #(.ITER_PER_CYCLE(8), .BIAS(127)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .div_zero(div_zero8)
    );

    typedef struct packed {
        logic [15:0] r;
        logic        dz;
        logic        sp;
    } exp_t;

    // Reference: quotient significand is the integer quotient of scaled significands.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        int   ex, ey, sa, sb, qq, ee;
        logic s;
        s  = x[15] ^ y[15];
        ex = int'(x[14:7]);
        ey = int'(y[14:7]);
        e  = '0;
        e.sp = 1'b1;
`ifdef BF16_DIV_SPECIALS_EN
        if ((ex == 255 && x[6:0] != 0) || (ey == 255 && y[6:0] != 0) || (ex == 255 && ey == 255)) begin
            e.r = 16'h7FC0;
            return e;
        end
        if (ex == 255) begin e.r = {s, 8'hFF, 7'h00}; return e; end
        if (ey == 255) begin e.r = {s, 15'h0000}; return e; end
`endif
        if (ex == 0 && ey == 0) begin e.r = 16'h7FC0; return e; end
        if (ex == 0) begin e.r = {s, 15'h0000}; return e; end
        if (ey == 0) begin e.r = {s, 8'hFF, 7'h00}; e.dz = 1'b1; return e; end
        e.sp = 1'b0;
        sa = 128 + int'(x[6:0]);
        sb = 128 + int'(y[6:0]);
        ee = ex - ey + 127;
        if (sa >= sb) begin
            qq = (sa * 128) / sb;
        end else begin
            qq = (sa * 256) / sb;
            ee = ee - 1;
        end
        if (ee <= 0)        e.r = {s, 15'h0000};
        else if (ee >= 255) e.r = {s, 8'hFF, 7'h00};
        else                e.r = {s, 8'(ee), 7'(qq)};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    exp_t sbq[$];
    int   accq[$];
    bit   first = 1'b1;

    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            accq.delete();
            first = 1'b1;
        end else begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("sb_result", 32'(result), 32'(sbq[0].r));
                    chk("sb_div_zero", 32'(div_zero), 32'(sbq[0].dz));
                    if (first) begin
                        chk("sb_latency", 32'(cyc - accq[0]), sbq[0].sp ? 32'd1 : 32'd9);
                        first = 1'b0;
                    end
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        void'(accq.pop_front());
                        first = 1'b1;
                    end
                end
            end
            if (in_valid && in_ready) begin
                sbq.push_back(model(a, b));
                accq.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y);
        int n;
        a = x;
        b = y;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic directed(input string name, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] want_r, input logic want_dz);
        send(x, y);
        wait_out();
        chk({name, "_result"}, 32'(result), 32'(want_r));
        chk({name, "_div_zero"}, 32'(div_zero), 32'(want_dz));
    endtask

    function automatic logic [15:0] rand_bf();
        logic [7:0] e;
        case ($urandom_range(0, 9))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'(($urandom_range(0, 1) != 0) ? $urandom_range(1, 4) : $urandom_range(250, 254));
            3, 4:    e = 8'($urandom_range(1, 254));
            default: e = 8'($urandom_range(107, 147));
        endcase
        return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
    endfunction

    initial begin
        int n;
        logic [15:0] x, y;
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0;
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid8", 32'(out_valid8), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed("div_6_2",     16'h40C0, 16'h4000, 16'h4040, 1'b0);
        directed("div_1_3",     16'h3F80, 16'h4040, 16'h3EAA, 1'b0);
        directed("div_m1_0",    16'hBF80, 16'h0000, 16'hFF80, 1'b1);
        directed("div_0_0",     16'h0000, 16'h0000, 16'h7FC0, 1'b0);
        directed("div_0_2",     16'h0000, 16'h4000, 16'h0000, 1'b0);
        directed("div_overflow",  16'h7F00, 16'h0080, 16'h7F80, 1'b0);
        directed("div_underflow", 16'h0080, 16'h7F00, 16'h0000, 1'b0);

        @(posedge clk);
        #1;
        a8 = 16'h3F80;
        b8 = 16'h4040;
        in_valid8 = 1'b1;
        @(negedge clk);
        chk("iter8_in_ready", 32'(in_ready8), 32'd1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        n = 1;
        while (!out_valid8 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("iter8_latency", 32'(n), 32'd2);
        chk("iter8_result", 32'(result8), 32'h3EAA);
        chk("iter8_div_zero", 32'(div_zero8), 32'd0);

        ready_mode = 2;
        send(16'h40C0, 16'h4000);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a = rand_bf();
            b = rand_bf();
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_result", 32'(result), 32'h4040);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_single_transfer", 32'(sbq.size()), 32'd0);

        send(16'h3F80, 16'h4040);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_div_zero", 32'(div_zero), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        directed("post_rst_6_2", 16'h40C0, 16'h4000, 16'h4040, 1'b0);

        ready_mode = 1;
        for (int i = 0; i < 400; i++) begin
            x = rand_bf();
            y = rand_bf();
            send(x, y);
        end
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'(sbq.size()), 32'd0);
        ready_mode = 0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
